hilo_unit: RTL and testbench

- HI/LO result stage that sits directly downstream of the team's 32x32 combinational signed multiplier (`mult`: ports a, b, z, busy).
- Latches operands for a MULT/MULTU instruction and drives them to the multiplier.
- Gives the multiplier's long combinational path a fixed multicycle window, applies the unsigned correction for MULTU, and writes the 64-bit result into the architectural HI/LO registers.
- Also services MTHI/MTLO writes and raises a pipeline stall while a multiply is in flight.

---
 rtl/hilo_unit.sv | 98 +++++++++
 tb/tb_hilo_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// HI/LO result stage behind the combinational 32x32 signed multiplier:
// registers operands, waits a fixed multicycle window, corrects for MULTU and writes HI/LO.
module hilo_unit #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_unsigned,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic [63:0] mult_z,
    input  logic        mult_busy,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall,
    output logic        done
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        uns_q;
    logic        done_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] a_q, b_q;
    logic [63:0] prod_d;

    // The multiplier is signed; for MULTU add back b (resp. a) times 2^32 when a (resp. b)
    // had its top bit set. Only the low 32 bits of the correction survive the shift.
    function automatic logic [63:0] correct_product(input logic [63:0] z,
                                                    input logic [31:0] a,
                                                    input logic [31:0] b,
                                                    input logic        uns);
        logic [31:0] corr;
        corr = ({32{uns & a[31]}} & b) + ({32{uns & b[31]}} & a);
        return z + {corr, 32'b0};
    endfunction

    assign prod_d = correct_product(mult_z, a_q, b_q, uns_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            uns_q   <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        uns_q   <= op_unsigned;
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                WAIT: begin
                    // Window expiry alone is not enough: a busy multiplier stretches the wait.
                    if (cnt_q == 4'd0 && !mult_busy) begin
                        hi_q    <= prod_d[63:32];
                        lo_q    <= prod_d[31:0];
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall  = (state_q == WAIT) | ((state_q == IDLE) & start & ~rst);
    assign done   = done_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign mult_a = a_q;
    assign mult_b = b_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: behavioural HI/LO model with per-cycle compare, directed literal pins
// and randomized multiply / MTHI / MTLO / busy traffic.
module tb_hilo_unit;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, start, op_unsigned, mult_busy, mthi, mtlo;
    logic [31:0] op_a, op_b, wdata;
    logic [31:0] mult_a, mult_b, hi, lo;
    logic [63:0] mult_z, sa, sb;
    logic        stall, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hilo_unit #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op_unsigned(op_unsigned),
        .op_a(op_a), .op_b(op_b), .mult_a(mult_a), .mult_b(mult_b),
        .mult_z(mult_z), .mult_busy(mult_busy), .mthi(mthi), .mtlo(mtlo),
        .wdata(wdata), .hi(hi), .lo(lo), .stall(stall), .done(done)
    );

    // Stand-in for the combinational signed multiplier
    assign sa     = {{32{mult_a[31]}}, mult_a};
    assign sb     = {{32{mult_b[31]}}, mult_b};
    assign mult_z = sa * sb;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pending multiply result, edges spent waiting, architectural HI/LO
    bit          m_wait = 1'b0, m_done = 1'b0, chk_en = 1'b0;
    int          m_edges = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_ma = '0, m_mb = '0;
    logic [63:0] m_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_wait = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_ma = '0; m_mb = '0;
            chk_en = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_wait) begin
                m_edges++;
                if (m_edges >= MUL_LAT && !mult_busy) begin
                    m_hi = m_res[63:32]; m_lo = m_res[31:0]; m_done = 1'b1; m_wait = 1'b0;
                end
            end else if (start) begin
                m_wait = 1'b1; m_edges = 0; m_ma = op_a; m_mb = op_b;
                if (op_unsigned) m_res = {32'd0, op_a} * {32'd0, op_b};
                else             m_res = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
            end else begin
                if (mthi) m_hi = wdata;
                if (mtlo) m_lo = wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hi", {32'd0, hi}, {32'd0, m_hi});
            check("lo", {32'd0, lo}, {32'd0, m_lo});
            check("done", {63'd0, done}, {63'd0, m_done});
            check("stall", {63'd0, stall}, {63'd0, m_wait || (start && !rst)});
            check("mult_a", {32'd0, mult_a}, {32'd0, m_ma});
            check("mult_b", {32'd0, mult_b}, {32'd0, m_mb});
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Call #1 after a rising edge. mode 0: quiet, 1: MTHI 0xDEADBEEF during WAIT, 2: random noise.
    task automatic mult_op(input bit uns, input logic [31:0] a, input logic [31:0] b,
                           input int nbusy, input int mode,
                           output int sc, output logic [31:0] rh, output logic [31:0] rl);
        bit got;
        int i;
        got = 1'b0; i = 0; sc = 0; rh = '0; rl = '0;
        start = 1'b1; op_unsigned = uns; op_a = a; op_b = b;
        while (!got && i < 60) begin
            @(negedge clk);
            if (stall) sc++;
            if (done) begin
                got = 1'b1; rh = hi; rl = lo;
            end else begin
                @(posedge clk); #1;
                start     = 1'b0;
                mult_busy = (nbusy > 0) && (i + 1 <= MUL_LAT + nbusy - 1);
                if (mode == 1) begin
                    mthi  = (i + 1 <= MUL_LAT + nbusy);
                    wdata = 32'hDEAD_BEEF;
                end else if (mode == 2) begin
                    mthi  = 1'($urandom); mtlo = 1'($urandom); wdata = $urandom;
                    op_a  = $urandom; op_b = $urandom; op_unsigned = 1'($urandom);
                    start = (i + 1 < MUL_LAT) ? 1'($urandom) : 1'b0;
                end
                i++;
            end
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL done_timeout actual=none expected=pulse within 60 cycles");
        end
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mult_busy = 1'b0;
    endtask

    int          sc, nb;
    logic [31:0] rh, rl;

    initial begin
        rst = 1'b1; start = 1'b0; op_unsigned = 1'b0; op_a = '0; op_b = '0;
        mult_busy = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;

        mult_op(1'b0, 32'hFFFF_FFFD, 32'd5, 0, 0, sc, rh, rl);
        check("m3x5_stall_len", 64'(sc), 64'd3);
        check("m3x5_hi", {32'd0, rh}, 64'hFFFF_FFFF);
        check("m3x5_lo", {32'd0, rl}, 64'hFFFF_FFF1);
        mult_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, sc, rh, rl);
        check("multu_ff_hi", {32'd0, rh}, 64'hFFFF_FFFE);
        check("multu_ff_lo", {32'd0, rl}, 64'h0000_0001);
        mult_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, sc, rh, rl);
        check("mult_ff_hi", {32'd0, rh}, 64'd0);
        check("mult_ff_lo", {32'd0, rl}, 64'd1);
        mult_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, 0, sc, rh, rl);
        check("mult_min_hi", {32'd0, rh}, 64'h4000_0000);
        check("mult_min_lo", {32'd0, rl}, 64'd0);
        mult_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0, 0, sc, rh, rl);
        check("multu_min_hi", {32'd0, rh}, 64'h4000_0000);
        check("multu_min_lo", {32'd0, rl}, 64'd0);

        mthi = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk); check("mthi_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1 mthi = 1'b0; mtlo = 1'b1; wdata = 32'h9ABC_DEF0;
        @(negedge clk);
        check("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        check("mtlo_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1 mtlo = 1'b0;
        @(negedge clk); check("mtlo_lo", {32'd0, lo}, 64'h9ABC_DEF0);
        @(posedge clk); #1;

        mult_op(1'b0, 32'h0001_2345, 32'hFFFF_FF00, 0, 1, sc, rh, rl);
        check("wait_mthi_hi", {32'd0, rh}, 64'hFFFF_FFFF);
        check("wait_mthi_lo", {32'd0, rl}, 64'hFEDC_BB00);

        mult_op(1'b1, 32'hFFFF_FFFF, 32'd2, 4, 0, sc, rh, rl);
        check("busy_stall_len", 64'(sc), 64'(MUL_LAT + 1 + 4));
        check("busy_hi", {32'd0, rh}, 64'd1);
        check("busy_lo", {32'd0, rl}, 64'hFFFF_FFFE);

        start = 1'b1; op_unsigned = 1'b0; op_a = 32'h0000_1111; op_b = 32'h0000_2222;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_stall", {63'd0, stall}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        repeat (3) begin
            @(negedge clk); check("abort_no_done", {63'd0, done}, 64'd0);
        end
        @(posedge clk); #1;
        mult_op(1'b0, 32'd7, 32'd6, 0, 0, sc, rh, rl);
        check("m7x6_hi", {32'd0, rh}, 64'd0);
        check("m7x6_lo", {32'd0, rl}, 64'd42);

        repeat (150) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
                    mult_op(1'($urandom), pick(), pick(), nb, 2, sc, rh, rl);
                    check("rand_stall_len", 64'(sc), 64'(MUL_LAT + 1 + nb));
                end
                6, 7: begin
                    mthi = 1'($urandom); mtlo = 1'($urandom); wdata = $urandom;
                    @(posedge clk); #1 mthi = 1'b0; mtlo = 1'b0;
                end
                default: begin
                    mult_busy = 1'($urandom);
                    @(posedge clk); #1 mult_busy = 1'b0;
                end
            endcase
        end

        repeat (2) @(posedge clk);
        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
